uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, the downstream counterpart of the team's UART transmitter; it consumes the serial line that transmitter drives. It oversamples `rx` with a baud tick, recovers start/data/parity/stop framing (LSB first, idle-high), and presents each received word with a one-cycle `rx_done` strobe plus parity and framing error flags. It is parameterised with the same framing parameters as the transmitter so a matched pair is configured identically.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity-mode constants
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_rx_state_t;

  localparam int unsigned UART_PARITY_EVEN = 0;
  localparam int unsigned UART_PARITY_ODD  = 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/parity/stop recovery, LSB first.
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchroniser first.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned SB_TICKS   = 1,
  parameter int unsigned IS_PARITY  = 0,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned S_W = $clog2(OVERSAMPLE);
  localparam int unsigned N_W = $clog2(DATA_BITS + 1);

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0] N_DATA = N_W'(DATA_BITS);
  localparam logic [N_W-1:0] N_STOP = N_W'(SB_TICKS);
  localparam logic           PAR_REF = (PARITY == UART_PARITY_EVEN) ? 1'b0 : 1'b1;
  localparam logic           HAS_PAR = (IS_PARITY != 0);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  uart_rx_state_t       state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d, n_inc;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d, fe_acc;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // n counts data bits in DATA and stop samples in STOP; it is cleared on each hand-off.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    n_inc   = n_q + N_W'(1);
    fe_acc  = fe_q | ~rx_s;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
              pe_d    = 1'b0;
              fe_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d  = '0;
            sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
            n_d  = n_inc;
            if (n_inc == N_DATA) begin
              n_d     = '0;
              state_d = HAS_PAR ? PAR : STOP;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            pe_d    = ((^sh_q) ^ rx_s) != PAR_REF;
            state_d = STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d  = '0;
            fe_d = fe_acc;
            n_d  = n_inc;
            if (n_inc == N_STOP) begin
              n_d     = '0;
              dout_d  = sh_q;
              perr_d  = HAS_PAR ? pe_q : 1'b0;
              ferr_d  = fe_acc;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_dout    = dout_q;
  assign rx_done    = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed scoreboard bench for uart_receiver: three instances cover 8N1,
// 8E1 and 8N2 framing, OVERSAMPLE=16 with s_tick every 4 clk.
module tb_uart_receiver;

  localparam int BIT_CLK = 64;

  logic clk;
  logic reset;
  logic s_tick;
  logic rx0, rx1, rx2;

  logic [7:0] dout0, dout1, dout2;
  logic done0, done1, done2;
  logic perr0, perr1, perr2;
  logic ferr0, ferr1, ferr2;
  logic busy0, busy1, busy2;

  uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(0), .PARITY(0), .OVERSAMPLE(16)) dut_n1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0),
    .rx_dout(dout0), .rx_done(done0), .parity_err(perr0), .frame_err(ferr0), .rx_busy(busy0)
  );

  uart_receiver #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(1), .PARITY(0), .OVERSAMPLE(16)) dut_p (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx1),
    .rx_dout(dout1), .rx_done(done1), .parity_err(perr1), .frame_err(ferr1), .rx_busy(busy1)
  );

  uart_receiver #(.DATA_BITS(8), .SB_TICKS(2), .IS_PARITY(0), .PARITY(0), .OVERSAMPLE(16)) dut_s2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx2),
    .rx_dout(dout2), .rx_done(done2), .parity_err(perr2), .frame_err(ferr2), .rx_busy(busy2)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int tick_total  = 0;
  int last_tick_cyc = -1;
  int lat_start   = 0;

  logic [7:0] held_dout [3];
  logic       held_perr [3];
  logic       held_ferr [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int ph;
    ph = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      s_tick = (ph == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (s_tick) begin
        tick_total++;
        last_tick_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d frames outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, perr, ferr, dout}
  function automatic logic [11:0] outs_of(input int id);
    case (id)
      0:       return {busy0, done0, perr0, ferr0, dout0};
      1:       return {busy1, done1, perr1, ferr1, dout1};
      default: return {busy2, done2, perr2, ferr2, dout2};
    endcase
  endfunction

  task automatic on_done(input int id);
    logic [11:0] o;
    exp_t e;
    o = outs_of(id);
    chk($sformatf("u%0d_done_expected", id), (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_dut"},  id,     e.id);
      chk({e.tag, "_dout"}, o[7:0], e.data);
      chk({e.tag, "_perr"}, o[9],   e.perr);
      chk({e.tag, "_ferr"}, o[8],   e.ferr);
      chk({e.tag, "_latency_ticks"}, tick_total - lat_start, e.lat);
      chk({e.tag, "_done_after_tick_edge"}, (last_tick_cyc == cyc), 1);
      held_dout[e.id] = e.data;
      held_perr[e.id] = e.perr;
      held_ferr[e.id] = e.ferr;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done0) on_done(0);
      if (done1) on_done(1);
      if (done2) on_done(2);
    end
  end

  task automatic set_rx(input int id, input logic v);
    case (id)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input bit has_par,
                            input logic pb, input int nstop, input logic stopv,
                            input int last_len);
    set_rx(id, 1'b0);
    @(posedge clk);
    #1 lat_start = tick_total;
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(id, d[i]);
      hold(BIT_CLK);
    end
    if (has_par) begin
      set_rx(id, pb);
      hold(BIT_CLK);
    end
    for (int k = 0; k < nstop; k++) begin
      set_rx(id, stopv);
      hold((k == nstop - 1) ? last_len : BIT_CLK);
    end
    set_rx(id, 1'b1);
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic pe, input logic fe,
                      input int lat, input string tag);
    exp_t e;
    e.id = id; e.data = d; e.perr = pe; e.ferr = fe; e.lat = lat; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk({tag, "_pending_frames"}, sb.size(), 0);
  endtask

  task automatic chk_held(input int id, input string tag);
    logic [11:0] o;
    o = outs_of(id);
    chk({tag, "_busy"}, o[11],  1'b0);
    chk({tag, "_dout"}, o[7:0], held_dout[id]);
    chk({tag, "_perr"}, o[9],   held_perr[id]);
    chk({tag, "_ferr"}, o[8],   held_ferr[id]);
  endtask

  initial begin
    logic [7:0] d5a;
    logic [11:0] o;

    reset = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      held_dout[i] = '0; held_perr[i] = 1'b0; held_ferr[i] = 1'b0;
    end
    hold(5);
    for (int i = 0; i < 3; i++) begin
      o = outs_of(i);
      chk($sformatf("reset_u%0d_all_outputs", i), o, 12'h000);
    end
    reset = 1'b1;
    hold(20);

    // 8N1 clean frame with latency 8+16*9 ticks
    push(0, 8'hA5, 1'b0, 1'b0, 152, "n1_A5");
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, BIT_CLK);
    drain("n1_A5");
    hold(20);
    chk_held(0, "n1_A5_hold");

    // even parity: 0x37 has five ones, so a parity bit of 1 is correct
    push(1, 8'h37, 1'b0, 1'b0, 168, "p_37_good");
    send_frame(1, 8'h37, 1'b1, 1'b1, 1, 1'b1, BIT_CLK);
    drain("p_37_good");
    hold(20);
    push(1, 8'h37, 1'b1, 1'b0, 168, "p_37_bad");
    send_frame(1, 8'h37, 1'b1, 1'b0, 1, 1'b1, BIT_CLK);
    drain("p_37_bad");
    hold(20);
    chk_held(1, "p_37_bad_hold");

    // stop bit low only through its centre so the tail reads as a false start
    push(0, 8'h3C, 1'b0, 1'b1, 152, "n1_3C_framing");
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 40);
    drain("n1_3C_framing");
    hold(100);
    chk_held(0, "n1_3C_hold");
    push(0, 8'h11, 1'b0, 1'b0, 152, "n1_11_clean");
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, BIT_CLK);
    drain("n1_11_clean");
    hold(20);

    // glitch: four ticks low, then high
    set_rx(0, 1'b0);
    hold(16);
    set_rx(0, 1'b1);
    o = outs_of(0);
    chk("glitch_busy_rise", o[11], 1'b1);
    hold(BIT_CLK);
    chk_held(0, "glitch_after");

    // back-to-back frames, two stop bits, no idle gap
    push(2, 8'h00, 1'b0, 1'b0, 168, "s2_00");
    push(2, 8'hFF, 1'b0, 1'b0, 168, "s2_FF");
    send_frame(2, 8'h00, 1'b0, 1'b0, 2, 1'b1, BIT_CLK);
    send_frame(2, 8'hFF, 1'b0, 1'b0, 2, 1'b1, BIT_CLK);
    drain("s2_b2b");
    hold(20);
    chk_held(2, "s2_b2b_hold");

    // reset pulsed during data bit 4 of 0x5A
    d5a = 8'h5A;
    set_rx(0, 1'b0);
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, d5a[i]);
      hold(BIT_CLK);
    end
    set_rx(0, d5a[4]);
    hold(32);
    o = outs_of(0);
    chk("midframe_busy_before_reset", o[11], 1'b1);
    reset = 1'b0;
    #1;
    o = outs_of(0);
    chk("midframe_reset_outputs", o, 12'h000);
    for (int i = 0; i < 3; i++) begin
      held_dout[i] = '0; held_perr[i] = 1'b0; held_ferr[i] = 1'b0;
    end
    set_rx(0, 1'b1);
    hold(4);
    reset = 1'b1;
    hold(BIT_CLK * 6);
    chk_held(0, "midframe_after_release");
    push(0, 8'h81, 1'b0, 1'b0, 152, "n1_81_after_reset");
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, BIT_CLK);
    drain("n1_81");
    hold(40);
    chk_held(0, "n1_81_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
